// File: rtl/sdram_arbiter.sv
// Three-port arbiter in front of a byte-wide SDRAM controller. Port 0 wins by
// priority, capped by HOG_LIMIT while others wait; ports 1 and 2 alternate.
module sdram_arbiter #(
    parameter int ADDR_W    = 23,
    parameter int HOG_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        req_rd,
    input  logic [2:0]        req_wr,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [ADDR_W-1:0] req_addr2,
    input  logic [7:0]        req_wdata0,
    input  logic [7:0]        req_wdata1,
    input  logic [7:0]        req_wdata2,
    output logic [7:0]        rdata,
    output logic [2:0]        done,
    output logic [2:0]        grant,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic [7:0]        ctl_wdata,
    output logic              ctl_rd,
    output logic              ctl_wr,
    input  logic [7:0]        ctl_rdata,
    input  logic              ctl_busy,
    output logic [1:0]        dbg_state
);

    // Requests are levels held until done[n]; the requester drops them in the
    // done cycle, otherwise that IDLE cycle may accept them as a new access.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2,
        WAIT   = 2'd3
    } state_t;

    localparam logic [3:0] HOG_MAX = 4'(HOG_LIMIT);

    state_t            state_q, state_d;
    logic [2:0]        grant_q, grant_d;
    logic [2:0]        done_q, done_d;
    logic              ctl_rd_q, ctl_rd_d;
    logic              ctl_wr_q, ctl_wr_d;
    logic [7:0]        rdata_q, rdata_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              op_wr_q, op_wr_d;
    logic              rr_two_q, rr_two_d;   // 1: port 2 is next among 1/2
    logic [3:0]        hog_q, hog_d;

    logic [2:0] pend;
    logic       others;
    logic [2:0] sel;

    always_comb begin
        pend   = req_rd | req_wr;
        others = pend[1] | pend[2];
        sel    = 3'b000;
        if (pend[0] && (hog_q < HOG_MAX || !others)) begin
            sel = 3'b001;
        end else if (pend[1] && (!rr_two_q || !pend[2])) begin
            sel = 3'b010;
        end else if (pend[2]) begin
            sel = 3'b100;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        done_d   = 3'b000;
        ctl_rd_d = 1'b0;
        ctl_wr_d = 1'b0;
        rdata_d  = rdata_q;
        wdata_d  = wdata_q;
        addr_d   = addr_q;
        op_wr_d  = op_wr_q;
        rr_two_d = rr_two_q;
        hog_d    = hog_q;
        unique case (state_q)
            IDLE: begin
                if (sel != 3'b000 && !ctl_busy) begin
                    grant_d  = sel;
                    op_wr_d  = |(req_wr & sel);
                    addr_d   = sel[0] ? req_addr0 : (sel[1] ? req_addr1 : req_addr2);
                    wdata_d  = sel[0] ? req_wdata0 : (sel[1] ? req_wdata1 : req_wdata2);
                    ctl_wr_d = op_wr_d;
                    ctl_rd_d = !op_wr_d;
                    if (sel[0]) begin
                        if (!others)              hog_d = 4'd0;
                        else if (hog_q != 4'd15) hog_d = hog_q + 4'd1;
                    end else begin
                        hog_d    = 4'd0;
                        rr_two_d = sel[1];
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE:  state_d = SETTLE;
            // Gives the controller a cycle to raise busy before it is sampled.
            SETTLE: state_d = WAIT;
            WAIT: begin
                if (!ctl_busy) begin
                    done_d  = grant_q;
                    grant_d = 3'b000;
                    if (!op_wr_q) rdata_d = ctl_rdata;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= 3'b000;
            done_q   <= 3'b000;
            ctl_rd_q <= 1'b0;
            ctl_wr_q <= 1'b0;
            rdata_q  <= 8'h00;
            wdata_q  <= 8'h00;
            addr_q   <= '0;
            op_wr_q  <= 1'b0;
            rr_two_q <= 1'b0;
            hog_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            ctl_rd_q <= ctl_rd_d;
            ctl_wr_q <= ctl_wr_d;
            rdata_q  <= rdata_d;
            wdata_q  <= wdata_d;
            addr_q   <= addr_d;
            op_wr_q  <= op_wr_d;
            rr_two_q <= rr_two_d;
            hog_q    <= hog_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign ctl_rd    = ctl_rd_q;
    assign ctl_wr    = ctl_wr_q;
    assign rdata     = rdata_q;
    assign ctl_addr  = addr_q;
    assign ctl_wdata = wdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: transaction-level reference model, emulated SDRAM
// controller with random busy/refresh, directed scenarios then random traffic.
module tb_sdram_arbiter;
    localparam int ADDR_W    = 23;
    localparam int HOG_LIMIT = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [2:0]        req_rd = 3'b000;
    logic [2:0]        req_wr = 3'b000;
    logic [ADDR_W-1:0] r_addr [3];
    logic [7:0]        r_wdata [3];
    logic [ADDR_W-1:0] req_addr0, req_addr1, req_addr2;
    logic [7:0]        req_wdata0, req_wdata1, req_wdata2;
    logic [7:0]        rdata;
    logic [2:0]        done, grant;
    logic [ADDR_W-1:0] ctl_addr;
    logic [7:0]        ctl_wdata;
    logic              ctl_rd, ctl_wr;
    logic [7:0]        ctl_rdata = 8'h00;
    logic              ctl_busy = 1'b0;
    logic [1:0]        dbg_state;

    assign req_addr0  = r_addr[0];
    assign req_addr1  = r_addr[1];
    assign req_addr2  = r_addr[2];
    assign req_wdata0 = r_wdata[0];
    assign req_wdata1 = r_wdata[1];
    assign req_wdata2 = r_wdata[2];

    sdram_arbiter #(.ADDR_W(ADDR_W), .HOG_LIMIT(HOG_LIMIT)) dut (
        .clk(clk), .reset(reset), .req_rd(req_rd), .req_wr(req_wr),
        .req_addr0(req_addr0), .req_addr1(req_addr1), .req_addr2(req_addr2),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1), .req_wdata2(req_wdata2),
        .rdata(rdata), .done(done), .grant(grant), .ctl_addr(ctl_addr),
        .ctl_wdata(ctl_wdata), .ctl_rd(ctl_rd), .ctl_wr(ctl_wr),
        .ctl_rdata(ctl_rdata), .ctl_busy(ctl_busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int cycle = 0, n_tests = 0, n_fail = 0;
    logic [7:0] exp_q [$];
    logic [7:0] mem [32];
    logic [7:0] ref_mem [32];
    int busy_left = 0, hold_busy = 0, busy_len = 0;
    bit rand_mode = 1'b0;
    bit persist [3];
    bit r_cur_wr [3];
    int done_cnt [3];
    int rd_cnt = 0, wr_cnt = 0, last_strobe_cycle = 0;
    logic [ADDR_W-1:0] last_strobe_addr = '0;
    int grant_log [$];
    logic [7:0] wdata_log [$];
    logic [2:0] prev_grant = 3'b000;

    // Reference model: owner of the current access and its age in cycles.
    int m_owner = -1, m_age = 0, m_hog = 0, m_rr = 1;
    bit m_wr = 1'b0;
    logic [2:0] e_grant, e_done;
    logic e_rd, e_wr;
    logic [7:0] e_rdata, e_wdata;
    logic [ADDR_W-1:0] e_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
        end
    endtask

    task automatic fail_line(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event missing at cycle %0d", name, cycle);
    endtask

    task automatic model_update();
        logic [2:0] pend;
        bit others;
        int win;
        e_done = 3'b000;
        e_rd   = 1'b0;
        e_wr   = 1'b0;
        if (reset) begin
            if (m_owner >= 0 && !m_wr) void'(exp_q.pop_back());
            m_owner = -1; m_hog = 0; m_rr = 1;
            e_grant = 3'b000; e_rdata = 8'h00; e_addr = '0; e_wdata = 8'h00;
        end else if (m_owner < 0) begin
            pend = req_rd | req_wr;
            if (pend != 3'b000 && !ctl_busy) begin
                others = pend[1] || pend[2];
                if (pend[0] && (m_hog < HOG_LIMIT || !others)) win = 0;
                else if (pend[m_rr]) win = m_rr;
                else win = 3 - m_rr;
                if (win == 0) m_hog = others ? ((m_hog < 15) ? m_hog + 1 : 15) : 0;
                else begin
                    m_hog = 0;
                    m_rr  = 3 - win;
                end
                m_owner = win;
                m_wr    = req_wr[win];
                m_age   = 0;
                e_grant = 3'(1 << win);
                e_addr  = r_addr[win];
                e_wdata = r_wdata[win];
                e_rd    = !m_wr;
                e_wr    = m_wr;
                if (m_wr) ref_mem[e_addr[4:0]] = e_wdata;
                else exp_q.push_back(ref_mem[e_addr[4:0]]);
            end
        end else begin
            // Accept, strobe, settle: completion is possible from age 3 on.
            m_age++;
            if (m_age >= 3 && !ctl_busy) begin
                e_done  = e_grant;
                e_grant = 3'b000;
                if (!m_wr) e_rdata = ctl_rdata;
                m_owner = -1;
            end
        end
    endtask

    task automatic compare();
        check("grant", 32'(grant), 32'(e_grant));
        check("done", 32'(done), 32'(e_done));
        check("ctl_rd", 32'(ctl_rd), 32'(e_rd));
        check("ctl_wr", 32'(ctl_wr), 32'(e_wr));
        check("rdata", 32'(rdata), 32'(e_rdata));
        check("ctl_addr", 32'(ctl_addr), 32'(e_addr));
        check("ctl_wdata", 32'(ctl_wdata), 32'(e_wdata));
    endtask

    task automatic launch(input int n, input int kind);
        r_addr[n]  = ADDR_W'($urandom_range(0, 63)) | (ADDR_W'($urandom_range(0, 7)) << 20);
        r_wdata[n] = 8'($urandom_range(0, 255));
        req_rd[n]  = (kind != 1);
        req_wr[n]  = (kind != 0);
        r_cur_wr[n] = (kind != 0);
    endtask

    task automatic set_req(input int n, input bit rd, input bit wr,
                           input logic [ADDR_W-1:0] a, input logic [7:0] d);
        r_addr[n]   = a;
        r_wdata[n]  = d;
        req_rd[n]   = rd;
        req_wr[n]   = wr;
        r_cur_wr[n] = wr;
    endtask

    task automatic env_react();
        bit load = 1'b0;
        int len = 0;
        logic [7:0] v;
        for (int n = 0; n < 3; n++) begin
            if (done[n]) begin
                done_cnt[n]++;
                if (!r_cur_wr[n]) begin
                    if (exp_q.size() == 0) fail_line("sb_rdata_expected");
                    else begin
                        v = exp_q.pop_front();
                        check("sb_rdata", 32'(rdata), 32'(v));
                    end
                end
            end
        end
        if (grant != 3'b000 && prev_grant == 3'b000)
            grant_log.push_back(grant[0] ? 0 : (grant[1] ? 1 : 2));
        prev_grant = grant;
        if (ctl_rd || ctl_wr) begin
            if (ctl_rd) rd_cnt++;
            if (ctl_wr) begin
                wr_cnt++;
                wdata_log.push_back(ctl_wdata);
                mem[ctl_addr[4:0]] = ctl_wdata;
            end else begin
                ctl_rdata = mem[ctl_addr[4:0]];
            end
            last_strobe_cycle = cycle;
            last_strobe_addr  = ctl_addr;
            load = 1'b1;
            len  = (busy_len < 0) ? int'($urandom_range(0, 4)) : busy_len;
        end
        if (hold_busy > 0) begin
            ctl_busy = 1'b1;
            hold_busy--;
        end else if (busy_left > 0) begin
            ctl_busy = 1'b1;
            busy_left--;
        end else begin
            ctl_busy = 1'b0;
        end
        if (load) busy_left = len;
        else if (rand_mode && busy_left == 0 && $urandom_range(0, 15) == 0)
            busy_left = $urandom_range(1, 4);
        for (int n = 0; n < 3; n++) begin
            if (done[n] && !persist[n]) begin
                req_rd[n] = 1'b0;
                req_wr[n] = 1'b0;
            end
        end
        if (rand_mode) begin
            reset = ($urandom_range(0, 399) == 0);
            for (int n = 0; n < 3; n++) begin
                if (!req_rd[n] && !req_wr[n]) begin
                    if (m_owner != n && $urandom_range(0, 3) == 0) launch(n, $urandom_range(0, 2));
                end else if ($urandom_range(0, 59) == 0) begin
                    req_rd[n] = 1'b0;
                    req_wr[n] = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
        model_update();
        compare();
        env_react();
    endtask

    task automatic wait_done(input int n, input int max_cyc);
        int k = 0;
        do begin
            step();
            k++;
        end while (!done[n] && k < max_cyc);
        if (!done[n]) fail_line($sformatf("timeout_done%0d", n));
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int t0;
        logic [31:0] seq;
        for (int i = 0; i < 32; i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        for (int n = 0; n < 3; n++) begin
            r_addr[n] = '0; r_wdata[n] = 8'h00;
            persist[n] = 1'b0; r_cur_wr[n] = 1'b0; done_cnt[n] = 0;
        end
        reset = 1'b1;
        repeat (3) step();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_ctl_rd", 32'(ctl_rd), 32'h0);
        check("rst_ctl_wr", 32'(ctl_wr), 32'h0);
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_ctl_addr", 32'(ctl_addr), 32'h0);
        check("rst_state", 32'(dbg_state), 32'h0);
        reset = 1'b0;

        // Single read on port 1 with a 3-cycle busy controller.
        busy_len = 3;
        mem[5] = 8'hA5;
        ref_mem[5] = 8'hA5;
        rd_cnt = 0; wr_cnt = 0;
        set_req(1, 1'b1, 1'b0, 23'h012345, 8'h00);
        t0 = cycle;
        wait_done(1, 30);
        check("rd_latency", 32'(cycle - t0), 32'd6);
        check("rd_strobes", 32'(rd_cnt), 32'd1);
        check("rd_strobe_addr", 32'(last_strobe_addr), 32'h012345);
        check("rd_data", 32'(rdata), 32'hA5);

        // Three simultaneous writes, busy never asserted.
        pulse_reset();
        busy_len = 0;
        grant_log.delete(); wdata_log.delete();
        for (int n = 0; n < 3; n++) done_cnt[n] = 0;
        set_req(0, 1'b0, 1'b1, 23'h000001, 8'h11);
        set_req(1, 1'b0, 1'b1, 23'h000002, 8'h22);
        set_req(2, 1'b0, 1'b1, 23'h000003, 8'h33);
        for (int k = 0; k < 40; k++) step();
        seq = 0;
        foreach (grant_log[i]) seq = (seq << 4) | 32'(grant_log[i]);
        check("wr3_grant_order", seq, 32'h012);
        seq = 0;
        foreach (wdata_log[i]) seq = (seq << 8) | 32'(wdata_log[i]);
        check("wr3_wdata", seq, 32'h112233);
        for (int n = 0; n < 3; n++) check($sformatf("wr3_done%0d", n), 32'(done_cnt[n]), 32'd1);

        // Port 0 hogging while port 2 waits: four port-0 grants, then port 2.
        pulse_reset();
        grant_log.delete();
        persist[0] = 1'b1;
        persist[2] = 1'b1;
        set_req(0, 1'b1, 1'b0, 23'h000010, 8'h00);
        set_req(2, 1'b1, 1'b0, 23'h000011, 8'h00);
        for (int k = 0; k < 100 && grant_log.size() < 10; k++) step();
        persist[0] = 1'b0;
        persist[2] = 1'b0;
        seq = 0;
        for (int i = 0; i < 10 && i < grant_log.size(); i++) seq = (seq << 2) | 32'(grant_log[i]);
        check("hog_grant_seq", seq, 32'h802);
        for (int k = 0; k < 30; k++) step();

        // Read and write together: the write wins, rdata stays put.
        pulse_reset();
        rd_cnt = 0; wr_cnt = 0;
        set_req(1, 1'b1, 1'b1, 23'h000007, 8'h5A);
        wait_done(1, 30);
        check("rdwr_wr_strobes", 32'(wr_cnt), 32'd1);
        check("rdwr_rd_strobes", 32'(rd_cnt), 32'd0);
        check("rdwr_rdata", 32'(rdata), 32'h00);
        check("rdwr_mem", 32'(mem[7]), 32'h5A);

        // Controller busy for 10 cycles in IDLE blocks the grant.
        repeat (3) step();
        rd_cnt = 0;
        ctl_busy = 1'b1;
        hold_busy = 9;
        t0 = cycle;
        set_req(0, 1'b1, 1'b0, 23'h000020, 8'h00);
        wait_done(0, 40);
        check("busy_strobe_cycle", 32'(last_strobe_cycle - t0), 32'd11);
        check("busy_strobes", 32'(rd_cnt), 32'd1);

        // Reset while waiting on the controller, then the held request again.
        repeat (3) step();
        busy_len = 5;
        done_cnt[1] = 0;
        set_req(1, 1'b1, 1'b0, 23'h012345, 8'h00);
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("wrst_grant", 32'(grant), 32'h0);
        check("wrst_done", 32'(done), 32'h0);
        check("wrst_strobes", 32'({ctl_rd, ctl_wr}), 32'h0);
        check("wrst_state", 32'(dbg_state), 32'h0);
        for (int k = 0; k < 40; k++) step();
        check("wrst_reserve_done", 32'(done_cnt[1]), 32'd1);

        // Random traffic, refresh and occasional resets.
        busy_len = -1;
        rand_mode = 1'b1;
        repeat (3000) step();
        rand_mode = 1'b0;
        reset = 1'b0;
        req_rd = 3'b000;
        req_wr = 3'b000;
        repeat (40) step();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit at cycle %0d", cycle);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single byte-wide SDRAM controller port between three requesters:
  - port 0: host Vector-06C (kvaz/main memory), latency-critical.
  - port 1: floppy workhorse sdram_iface window.
  - port 2: auxiliary/OSD loader.
- Serialises accesses, issues a one-cycle rd/wr strobe to the controller and tracks controller busy.
- Returns read data and a completion pulse to the granted requester.
- Port 0 has fixed priority, bounded by an anti-starvation limit; ports 1 and 2 are served round-robin.

Parameters:
- ADDR_W, 23, SDRAM byte address width.
- HOG_LIMIT, 4, maximum consecutive port-0 grants while port 1 or 2 is pending (1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_rd  in  3  per-port read request (bit n = port n), level, held until done
- req_wr  in  3  per-port write request, level, held until done
- req_addr0/1/2  in  ADDR_W each  per-port address
- req_wdata0/1/2  in  8 each  per-port write data
- rdata  out  8  read data register, valid when done[n] pulses
- done  out  3  one-cycle completion pulse per port
- grant  out  3  one-hot current owner; 0 when idle
- ctl_addr  out  ADDR_W  address to controller
- ctl_wdata  out  8  write data to controller
- ctl_rd  out  1  one-cycle read strobe
- ctl_wr  out  1  one-cycle write strobe
- ctl_rdata  in  8  controller read data
- ctl_busy  in  1  controller busy (access in progress or refresh)

Behaviour:
- Single clock. All state is updated on posedge clk. Reset is synchronous, active-high, and has priority over everything else.
- Reset values:
  - grant=0, done=0, ctl_rd=0, ctl_wr=0, rdata=0, ctl_addr=0, ctl_wdata=0.
  - state=IDLE, rr_ptr=1 (port 1 is next among ports 1/2), hog_cnt=0.
- A port is pending when req_rd[n] or req_wr[n] is high. If both are high, the access is a write.
- States:
  - IDLE:
    - Waits until a port is pending and ctl_busy=0.
    - Selection:
      - If port 0 is pending and (hog_cnt<HOG_LIMIT or ports 1/2 are idle), select port 0.
      - Otherwise select the pending port among 1/2 starting at rr_ptr.
      - If only port 0 is pending, it is always selected, regardless of hog_cnt.
    - Latches grant, ctl_addr, ctl_wdata and op, then goes to ISSUE.
  - ISSUE:
    - Asserts exactly one of ctl_rd/ctl_wr for one cycle, then goes to SETTLE.
  - SETTLE:
    - Waits one cycle unconditionally so the controller can raise busy, then goes to WAIT.
  - WAIT:
    - Stays while ctl_busy=1.
    - On ctl_busy=0: for a read, rdata<=ctl_rdata; done[grant] pulses for 1 cycle; grant clears; state goes to IDLE.
- Grant bookkeeping (done in IDLE):
  - Port 0 granted while port 1 or 2 is pending: hog_cnt++, saturating at 15.
  - Port 1 or 2 granted, or port 0 granted with ports 1/2 idle: hog_cnt=0.
  - Port 1 or 2 granted: rr_ptr points to the other of 1/2.
- Minimum transaction length is 4 cycles from IDLE acceptance (IDLE, ISSUE, SETTLE, WAIT with busy already low). The earliest new grant is the cycle after done.
- rdata holds its value until the next read completion; write completions leave it unchanged.
- ctl_addr and ctl_wdata stay stable from ISSUE through WAIT.
- If a requester deasserts after being granted, the transaction still completes and done still pulses.
- If a requester deasserts before being granted, it is not served.
- Requesters must drop the request on the cycle they see done. A request still high in the next IDLE cycle is treated as a new access.
- ctl_busy=1 in IDLE (e.g. refresh) blocks all grants. Nothing is latched until busy drops.
- Reset in any state: strobes drop that cycle, no done pulse is produced, and the aborted access is not retried.
- Address is passed through unmodified; there is no width arithmetic.

Test Plan:
- Single read, port 1, addr 0x012345, controller busy for 3 cycles, ctl_rdata=0xA5:
  - ctl_rd pulses once with ctl_addr=0x012345.
  - done[1] pulses 6 cycles after acceptance, with rdata=0xA5.
- Simultaneous: ports 0,1,2 all request writes (0x11,0x22,0x33), busy 0:
  - Grant order is 0,1,2.
  - Each ctl_wr carries the matching data.
  - Exactly one done per port.
- Starvation bound: port 0 requests continuously with HOG_LIMIT=4 while port 2 is pending:
  - Port 2 is granted after exactly 4 port-0 grants.
  - hog_cnt then resets.
- Port 1 asserts req_rd and req_wr together with wdata=0x5A:
  - A write is issued (ctl_wr=1, ctl_rd=0).
  - rdata is unchanged.
- ctl_busy held high for 10 cycles in IDLE while port 0 requests:
  - No strobe appears until the cycle after busy falls.
- Reset asserted in WAIT:
  - Next cycle: grant=0, done=0, strobes 0, state IDLE.
  - A held request is re-served afterward with exactly one done.
